// File: rtl/pingpong_unpacker.sv
// Fills banks A/B alternately and drains each closed bank as one valid/ready block; out_valid rises
// two edges after a bank closes, out_ready low stalls the current beat, samples hitting a busy bank are dropped and counted.
module pingpong_unpacker #(
  parameter int n_bits     = 4,
  parameter int depth_log2 = 4
) (
  input  logic              clock_rd,
  input  logic              reset_rd,
  input  logic [n_bits-1:0] data_in,
  input  logic              valid_in,
  input  logic              flush,
  output logic [n_bits-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              bank_out,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [2:0]        state_out
);

  localparam int DEPTH = 2 ** depth_log2;
  localparam logic [depth_log2-1:0] WR_ONE   = depth_log2'(1);
  localparam logic [depth_log2-1:0] WR_LAST  = '1;
  localparam logic [depth_log2-1:0] IDX0     = '0;
  localparam logic [depth_log2:0]   RD_ONE   = (depth_log2 + 1)'(1);

  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_FILLING = 2'd1, B_FULL = 2'd2} bank_st_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_STREAM = 2'd1} rd_state_t;

  logic [n_bits-1:0]   mem [2][DEPTH];
  bank_st_t            status [2];
  logic [depth_log2:0] len [2];
  logic                full_seen [2];

  logic                  wr_bank;
  logic [depth_log2-1:0] wr_ptr;
  bank_st_t              wr_st;
  logic                  accept;
  logic                  drop;
  logic                  close;
  logic [depth_log2:0]   fill_cnt;

  rd_state_t           rd_state, rd_state_nxt;
  logic                rd_bank, rd_bank_nxt;
  logic [depth_log2:0] rd_ptr, rd_ptr_nxt;
  logic [n_bits-1:0]   out_data_nxt;
  logic                out_valid_nxt, out_last_nxt, bank_out_nxt;
  logic                rd_full;
  logic                release_bank;

  // Write side decides purely on registered bank status.
  assign wr_st    = status[wr_bank];
  assign accept   = valid_in && (wr_st != B_FULL);
  assign drop     = valid_in && (wr_st == B_FULL);
  assign fill_cnt = {1'b0, wr_ptr} + {{depth_log2{1'b0}}, accept};
  assign close    = (wr_st != B_FULL) && (fill_cnt != '0) &&
                    (flush || (accept && (wr_ptr == WR_LAST)));

  always_ff @(posedge clock_rd) begin
    if (accept) mem[wr_bank][wr_ptr] <= data_in;
  end

  always_ff @(posedge clock_rd or negedge reset_rd) begin
    if (!reset_rd) begin
      for (int i = 0; i < 2; i++) begin
        status[i]    <= B_EMPTY;
        len[i]       <= '0;
        full_seen[i] <= 1'b0;
      end
      wr_bank    <= 1'b0;
      wr_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      for (int i = 0; i < 2; i++) full_seen[i] <= (status[i] == B_FULL);
      if (release_bank) status[rd_bank] <= B_EMPTY;
      if (close) begin
        status[wr_bank] <= B_FULL;
        len[wr_bank]    <= fill_cnt;
        wr_ptr          <= '0;
        wr_bank         <= ~wr_bank;
      end else if (accept) begin
        status[wr_bank] <= B_FILLING;
        wr_ptr          <= wr_ptr + WR_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  // A bank is picked up only after it has read FULL for a cycle, giving the two-edge start latency.
  assign rd_full = (status[rd_bank] == B_FULL) && full_seen[rd_bank];

  always_comb begin
    rd_state_nxt  = rd_state;
    rd_bank_nxt   = rd_bank;
    rd_ptr_nxt    = rd_ptr;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    bank_out_nxt  = bank_out;
    release_bank  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (rd_full) begin
          out_data_nxt  = mem[rd_bank][IDX0];
          out_valid_nxt = 1'b1;
          out_last_nxt  = (len[rd_bank] == RD_ONE);
          bank_out_nxt  = rd_bank;
          rd_ptr_nxt    = RD_ONE;
          rd_state_nxt  = R_STREAM;
        end
      end
      R_STREAM: begin
        if (out_valid && out_ready) begin
          if (out_last) begin
            release_bank  = 1'b1;
            rd_bank_nxt   = ~rd_bank;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            rd_state_nxt  = R_IDLE;
          end else begin
            out_data_nxt = mem[rd_bank][rd_ptr[depth_log2-1:0]];
            out_last_nxt = ((rd_ptr + RD_ONE) == len[rd_bank]);
            rd_ptr_nxt   = rd_ptr + RD_ONE;
          end
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clock_rd or negedge reset_rd) begin
    if (!reset_rd) begin
      rd_state  <= R_IDLE;
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      bank_out  <= 1'b0;
    end else begin
      rd_state  <= rd_state_nxt;
      rd_bank   <= rd_bank_nxt;
      rd_ptr    <= rd_ptr_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      bank_out  <= bank_out_nxt;
    end
  end

  assign state_out = {wr_bank, rd_state};

endmodule

// File: tb/tb_pingpong_unpacker.sv
// Bench for pingpong_unpacker: a bank/queue-level model checked every cycle, plus directed
// scenarios with literal expectations on beat order, block boundaries, latency and drop counting.
module tb_pingpong_unpacker;
  localparam int DEPTH = 16;

  logic        clock_rd = 1'b0;
  logic        reset_rd = 1'b0;
  logic [3:0]  data_in = '0;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  out_data;
  logic        out_valid, out_last, bank_out, overflow;
  logic [15:0] drop_count;
  logic [2:0]  state_out;

  pingpong_unpacker #(.n_bits(4), .depth_log2(4)) dut (
    .clock_rd(clock_rd), .reset_rd(reset_rd), .data_in(data_in), .valid_in(valid_in),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .bank_out(bank_out), .overflow(overflow),
    .drop_count(drop_count), .state_out(state_out));

  always #5 clock_rd = ~clock_rd;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each bank is a sample list plus a closed flag; a closed bank starts draining
  // two edges after it closed, once the previous block is gone.
  int m_mem [2][DEPTH];
  int m_cnt [2];
  bit m_closed [2];
  int m_close_edge [2];
  int m_wr, m_rd, m_idx, m_drops;
  bit m_stream, m_ovf, m_wclosed;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_cnt[b] = 0; m_closed[b] = 1'b0; m_close_edge[b] = -100;
    end
    m_wr = 0; m_rd = 0; m_idx = 0; m_drops = 0; m_stream = 1'b0; m_ovf = 1'b0;
  endfunction

  function automatic void model_step();
    m_wclosed = m_closed[m_wr];
    if (valid_in) begin
      if (m_wclosed) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end else begin
        m_mem[m_wr][m_cnt[m_wr]] = int'(data_in);
        m_cnt[m_wr]++;
      end
    end
    if (!m_wclosed && m_cnt[m_wr] > 0 && (flush || m_cnt[m_wr] == DEPTH)) begin
      m_closed[m_wr] = 1'b1;
      m_close_edge[m_wr] = cyc;
      m_wr ^= 1;
    end
    if (m_stream) begin
      if (out_ready) begin
        if (m_idx == m_cnt[m_rd] - 1) begin
          m_closed[m_rd] = 1'b0; m_cnt[m_rd] = 0; m_stream = 1'b0; m_rd ^= 1;
        end else m_idx++;
      end
    end else if (m_closed[m_rd] && cyc >= m_close_edge[m_rd] + 2) begin
      m_stream = 1'b1; m_idx = 0;
    end
  endfunction

  always @(posedge clock_rd) begin
    cyc++;
    if (!reset_rd) model_reset();
    else model_step();
    #1;
    if (reset_rd) begin
      chk("out_valid", int'(out_valid), int'(m_stream));
      if (m_stream) begin
        chk("out_data", int'(out_data), m_mem[m_rd][m_idx]);
        chk("out_last", int'(out_last), int'(m_idx == m_cnt[m_rd] - 1));
        chk("bank_out", int'(bank_out), m_rd);
      end else chk("out_last_idle", int'(out_last), 0);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("drop_count", int'(drop_count), m_drops);
      chk("state_out", int'(state_out), m_wr * 4 + int'(m_stream));
    end
  end

  typedef struct {int d; bit l; bit b; int t;} beat_t;
  beat_t beats[$];
  beat_t mb;

  always @(negedge clock_rd) begin
    if (reset_rd && out_valid && out_ready) begin
      mb.d = int'(out_data); mb.l = out_last; mb.b = bank_out; mb.t = cyc;
      beats.push_back(mb);
    end
  end

  task automatic step();
    @(posedge clock_rd);
    #2;
  endtask

  task automatic send(input int v, input bit fl);
    data_in = v[3:0]; valid_in = 1'b1; flush = fl;
    step();
    valid_in = 1'b0; flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int lim, input string nm);
    int k = 0;
    while (beats.size() < n && k < lim) begin step(); k++; end
    chk(nm, beats.size(), n);
  endtask

  task automatic chk_block(input string nm, input int first, input int n, input int exp_bank);
    for (int i = 0; i < n && i < beats.size(); i++) begin
      chk({nm, "_data"}, beats[i].d, (first + i) & 15);
      chk({nm, "_last"}, int'(beats[i].l), int'(i == n - 1));
      chk({nm, "_bank"}, int'(beats[i].b), exp_bank);
    end
  endtask

  int w_edge, k;

  initial begin
    // reset values
    step(); step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_state_out", int'(state_out), 0);
    chk("rst_drop_count", int'(drop_count), 0);
    reset_rd = 1'b1;
    step();

    // 1: full block, ready high
    out_ready = 1'b1; beats.delete();
    for (int i = 0; i < 16; i++) send(i, 1'b0);
    w_edge = cyc; k = 0;
    while (!out_valid && k < 10) begin step(); k++; end
    chk("t1_latency", cyc - w_edge, 2);
    wait_beats(16, 40, "t1_count");
    chk_block("t1", 0, 16, 0);
    if (beats.size() == 16) chk("t1_back_to_back", beats[15].t - beats[0].t, 15);
    chk("t1_overflow", int'(overflow), 0);
    repeat (3) step();

    // 2: ready toggling
    out_ready = 1'b0; beats.delete();
    for (int i = 0; i < 16; i++) send(i, 1'b0);
    k = 0;
    while (beats.size() < 16 && k < 80) begin out_ready = (k % 2 == 0); step(); k++; end
    chk("t2_count", beats.size(), 16);
    chk_block("t2", 0, 16, 1);
    out_ready = 1'b1;
    repeat (3) step();

    // 3: both banks full, overrun
    out_ready = 1'b0; beats.delete();
    for (int i = 0; i < 40; i++) send(i, 1'b0);
    repeat (3) step();
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_drop_count", int'(drop_count), 8);
    out_ready = 1'b1;
    wait_beats(32, 100, "t3_count");
    if (beats.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        chk("t3_data", beats[i].d, i & 15);
        chk("t3_last", int'(beats[i].l), int'(i == 15 || i == 31));
        chk("t3_bank", int'(beats[i].b), int'(i >= 16));
      end
      chk("t3_gap", beats[16].t - beats[15].t, 2);
      chk("t3_stream", beats[1].t - beats[0].t, 1);
    end
    repeat (3) step();

    // 4: flush of a partial block, flush on an empty bank
    beats.delete();
    for (int i = 0; i < 5; i++) send(i, 1'b0);
    do_flush();
    wait_beats(5, 20, "t4_count");
    chk_block("t4", 0, 5, 0);
    repeat (2) step();
    chk("t4_state", int'(state_out), 4);
    do_flush();
    repeat (4) step();
    chk("t4_noop_state", int'(state_out), 4);
    chk("t4_noop_beats", beats.size(), 5);
    send(12, 1'b0);
    do_flush();
    wait_beats(6, 20, "t4_bankb_count");
    if (beats.size() == 6) begin
      chk("t4_bankb_data", beats[5].d, 12);
      chk("t4_bankb_last", int'(beats[5].l), 1);
      chk("t4_bankb_bank", int'(beats[5].b), 1);
    end
    repeat (3) step();

    // 5: flush coinciding with a write
    beats.delete();
    send(7, 1'b0); send(8, 1'b0); send(9, 1'b0); send(10, 1'b1);
    wait_beats(4, 20, "t5_count");
    repeat (3) step();
    chk("t5_len", beats.size(), 4);
    chk_block("t5", 7, 4, 0);
    beats.delete();
    for (int i = 0; i < 16; i++) send(i + 3, i == 15);
    wait_beats(16, 40, "t5_full_count");
    repeat (6) step();
    chk("t5_no_empty_block", beats.size(), 16);
    chk_block("t5f", 3, 16, 1);
    repeat (3) step();

    // 6: reset mid-drain
    beats.delete();
    for (int i = 0; i < 16; i++) send(i, 1'b0);
    wait_beats(6, 40, "t6_pre_count");
    chk("t6_pre_overflow", int'(overflow), 1);
    reset_rd = 1'b0;
    #1;
    chk("t6_async_valid", int'(out_valid), 0);
    chk("t6_async_data", int'(out_data), 0);
    chk("t6_async_last", int'(out_last), 0);
    chk("t6_async_overflow", int'(overflow), 0);
    chk("t6_async_drops", int'(drop_count), 0);
    chk("t6_async_state", int'(state_out), 0);
    step();
    reset_rd = 1'b1;
    beats.delete();
    step();
    for (int i = 0; i < 16; i++) send(i + 5, 1'b0);
    wait_beats(16, 40, "t6_post_count");
    chk_block("t6", 5, 16, 0);
    repeat (4) step();
    chk("t6_post_beats", beats.size(), 16);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
